onchip_mem_block_master: RTL and testbench
==========================================

// Module: onchip_mem_block_master
// PURPOSE
//  Avalon-MM master that drives the single-port on-chip RAM slave (address/byteenable/chipselect/
//  write/writedata -> readdata, fixed read latency, no waitrequest). Executes block commands:
//  FILL (pattern to N words), COPY (src -> dst, N words), SUM (32-bit checksum of N words).
//  Sits between control logic and the RAM's s1 port; the RAM's s2 port stays free for the CPU.
// PARAMETERS
//  ADDR_W        10   word-address width; memory depth = 2**ADDR_W
//  DATA_W        32   data width; byteenable width = DATA_W/8
//  READ_LATENCY  1    cycles from read-address cycle to valid readdata (legal 1..3)
// PORTS
//  clk            in   1         system clock
//  reset_n        in   1         synchronous reset, active low
//  cmd_valid      in   1         command offered
//  cmd_ready      out  1         block idle, command accepted when cmd_valid&cmd_ready
//  cmd_op         in   2         0=FILL 1=COPY 2=SUM 3=reserved
//  cmd_src        in   ADDR_W    start word address for COPY/SUM reads
//  cmd_dst        in   ADDR_W    start word address for FILL/COPY writes
//  cmd_len        in   ADDR_W+1  word count, 0..2**ADDR_W
//  cmd_pattern    in   DATA_W    FILL data
//  busy           out  1         command in progress
//  done           out  1         one-cycle pulse on completion
//  err            out  1         valid with done: op was reserved
//  result         out  DATA_W    SUM result, held until next accepted command
//  avm_address    out  ADDR_W    RAM word address
//  avm_byteenable out  DATA_W/8  all ones on every access
//  avm_chipselect out  1         access strobe
//  avm_write      out  1         1=write, 0=read (qualified by chipselect)
//  avm_writedata  out  DATA_W    write data
//  avm_readdata   in   DATA_W    RAM read data
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state IDLE; cmd_ready,busy,done,err,avm_chipselect,avm_write=0;
//    result,avm_address,avm_writedata=0; avm_byteenable=all ones. Mid-command reset aborts at once;
//    RAM words already written stay written. cmd_ready=1 from first cycle after reset release.
//  - States: IDLE, FILL, RD, RWAIT, WR, DONE. Command latched on accept; cmd_ready=0 until DONE exits.
//  - FILL: one write per cycle, addr dst, dst+1, ...; N words take N cycles.
//  - COPY per word: RD (cs=1,write=0,addr=src+i), RWAIT for READ_LATENCY cycles, readdata captured
//    at end of last RWAIT cycle, WR (cs=1,write=1,addr=dst+i). 2+READ_LATENCY cycles/word.
//  - SUM per word: RD then RWAIT; captured word added to accumulator mod 2**DATA_W; no WR.
//  - chipselect=0 in IDLE, RWAIT and DONE; exactly one access per RD/WR/FILL cycle.
//  - Addresses wrap modulo 2**ADDR_W (e.g. 10'h3FF+1 -> 10'h000).
//  - Words processed in ascending order; overlapping COPY with dst>src replicates data (defined, not an error).
//  - cmd_len=0 or cmd_op=3: no memory access; DONE next cycle; err=1 only for op 3; SUM of 0 words -> result 0.
//  - cmd_len>2**ADDR_W clamps to 2**ADDR_W.
//  - DONE: done=1 one cycle, busy=0 the following cycle, back to IDLE; result updated in the same cycle done rises.
//  - busy=1 from cycle after accept through DONE inclusive. cmd_valid while busy is ignored (no queue).
// TESTING
//  1 FILL dst=0x3FC len=8 pat=A5A5A5A5 -> writes at 3FC..3FF,000..003; 8 cycles; done pulse; 0x3FB/0x004 untouched.
//  2 Preload 0x010..0x013={1,2,3,4}; COPY src=0x010 dst=0x100 len=4 -> 0x100..0x103={1,2,3,4}; 12 cycles at latency 1.
//  3 Preload 0x000..0x003={FFFFFFFF,2,3,4}; SUM len=4 -> result=0x00000008 (wraps), err=0.
//  4 cmd_len=0 (any op) and op=3 -> no chipselect; done one cycle after accept; err=0 / err=1 respectively.
//  5 reset_n=0 during 3rd word of COPY len=8 -> next cycle all outputs at reset values; words 0-1 copied, rest intact.
//  6 Repeat test 2 with READ_LATENCY=3 (RAM model delayed to match) -> same data, 5 cycles/word; cmd_valid while busy ignored.

Source files
------------

// File: rtl/onchip_mem_block_master.sv
// ---------------------------------------------------------------------------
// onchip_mem_block_master
//   Avalon-MM master for the s1 port of a single-port on-chip RAM (fixed read
//   latency, no waitrequest). Runs one block command at a time:
//     FILL : write cmd_pattern to N consecutive words starting at cmd_dst
//     COPY : read src+i, write dst+i, ascending, N words
//     SUM  : 32-bit wrap-around checksum of N words starting at cmd_src
//   Addresses wrap modulo the memory depth. A length of 0 or the reserved
//   opcode completes without touching memory.
// ---------------------------------------------------------------------------
module onchip_mem_block_master #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1    // legal 1..3
) (
  input  logic                clk,
  input  logic                reset_n,
  // command interface
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   cmd_pattern,
  // status
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   result,
  // Avalon-MM master towards the RAM
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RD,
    S_RWAIT,
    S_WR,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_FILL = 2'd0,
    OP_COPY = 2'd1,
    OP_SUM  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  // Largest legal word count: the whole memory.
  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  // RWAIT counts 0..LAT_LAST; readdata is valid in the last of those cycles.
  localparam logic [1:0]        LAT_LAST = 2'(READ_LATENCY - 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;     // words still to finish
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d; // word in flight for COPY
  logic [DATA_W-1:0]   acc_q, acc_d;     // running SUM
  logic [DATA_W-1:0]   result_q, result_d;
  logic                err_q, err_d;
  logic [1:0]          lat_q, lat_d;
  logic                ready_en_q, ready_en_d; // holds cmd_ready low while in reset

  logic [ADDR_W:0]     len_clamped;
  logic                accept;

  assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign cmd_ready   = (state_q == S_IDLE) && ready_en_q;
  assign accept      = cmd_valid && cmd_ready;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_FILL;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      pat_q      <= '0;
      rdata_q    <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      lat_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      rdata_q    <= rdata_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      err_q      <= err_d;
      lat_q      <= lat_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Next-state logic: command capture, address/count stepping, accumulate.
  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // the case below leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    rdata_d    = rdata_q;
    acc_d      = acc_q;
    result_d   = result_q;
    err_d      = err_q;
    lat_d      = lat_q;
    ready_en_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = op_e'(cmd_op);
          src_d = cmd_src;
          dst_d = cmd_dst;
          cnt_d = len_clamped;
          pat_d = cmd_pattern;
          acc_d = '0;
          err_d = (cmd_op == OP_RSVD);
          if (cmd_op == OP_RSVD || cmd_len == '0) begin
            state_d = S_DONE;
          end else if (cmd_op == OP_FILL) begin
            state_d = S_FILL;
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_FILL: begin
        dst_d = dst_q + ADDR_ONE;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_DONE;
      end

      S_RD: begin
        src_d   = src_q + ADDR_ONE;
        lat_d   = '0;
        state_d = S_RWAIT;
      end

      S_RWAIT: begin
        if (lat_q != LAT_LAST) begin
          lat_d = lat_q + 2'd1;
        end else if (op_q == OP_COPY) begin
          rdata_d = avm_readdata;
          state_d = S_WR;
        end else begin
          // SUM retires the word here; there is no write phase.
          acc_d   = acc_q + avm_readdata;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? S_DONE : S_RD;
        end
      end

      S_WR: begin
        dst_d   = dst_q + ADDR_ONE;
        cnt_d   = cnt_q - CNT_ONE;
        state_d = (cnt_q == CNT_ONE) ? S_DONE : S_RD;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // result changes on the same edge that raises done; non-SUM ops report 0.
    if (state_d == S_DONE && state_q != S_DONE) result_d = acc_d;
  end

  // Avalon and status outputs decoded from the registered state.
  always_comb begin
    avm_byteenable = '1;
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    unique case (state_q)
      S_FILL: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = dst_q;
        avm_writedata  = pat_q;
      end
      S_RD: begin
        avm_chipselect = 1'b1;
        avm_address    = src_q;
      end
      S_WR: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = dst_q;
        avm_writedata  = rdata_q;
      end
      default: begin
        avm_chipselect = 1'b0;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = done && err_q;
  assign result = result_q;

endmodule

// File: tb/tb_onchip_mem_block_master.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_block_master
//   Two masters share one command stream: one with READ_LATENCY=1, one with
//   READ_LATENCY=3, each driving its own RAM model with matching latency.
//   A vector table covers FILL/COPY/SUM, zero length, reserved op and length
//   clamping; hand-written sequences cover mid-command reset and commands
//   offered while busy.
// ---------------------------------------------------------------------------
module tb_onchip_mem_block_master;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BOUND = 5000;

  localparam logic [DW-1:0] S1 = 32'h5A5A_0001;
  localparam logic [DW-1:0] S2 = 32'h5A5A_0002;
  localparam logic [DW-1:0] S3 = 32'h5A5A_0003;

  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] pat;
    logic [15:0]   cyc1;   // cycles from accept to done, latency 1
    logic [15:0]   cyc3;   // same, latency 3
    logic [15:0]   acc;    // chipselect cycles
    logic          err;
    logic          chk;    // compare result
    logic [DW-1:0] res;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_src, cmd_dst;
  logic [AW:0]   cmd_len;
  logic [DW-1:0] cmd_pattern;

  logic          r0, b0, dn0, e0, cs0, w0;
  logic [DW-1:0] res0, wd0, rd0;
  logic [AW-1:0] a0;
  logic [3:0]    be0;
  logic          r1, b1, dn1, e1, cs1, w1;
  logic [DW-1:0] res1, wd1, rd1;
  logic [AW-1:0] a1;
  logic [3:0]    be1;

  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;

  logic [DW-1:0] mem0 [1024];
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] p0;
  logic [DW-1:0] p1 [3];

  int   total = 0;
  int   bad   = 0;
  vec_t vecs [10];
  vec_t vx;

  onchip_mem_block_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(r0), .cmd_op(cmd_op), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
    .busy(b0), .done(dn0), .err(e0), .result(res0),
    .avm_address(a0), .avm_byteenable(be0), .avm_chipselect(cs0),
    .avm_write(w0), .avm_writedata(wd0), .avm_readdata(rd0)
  );

  onchip_mem_block_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(r1), .cmd_op(cmd_op), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
    .busy(b1), .done(dn1), .err(e1), .result(res1),
    .avm_address(a1), .avm_byteenable(be1), .avm_chipselect(cs1),
    .avm_write(w1), .avm_writedata(wd1), .avm_readdata(rd1)
  );

  // RAM model, read latency 1 (plus a bench-side preload port).
  always @(posedge clk) begin
    if (pre_we) mem0[pre_a] <= pre_d;
    else if (cs0 && w0) mem0[a0] <= wd0;
    p0 <= mem0[a0];
  end
  assign rd0 = p0;

  // RAM model, read latency 3.
  always @(posedge clk) begin
    if (pre_we) mem1[pre_a] <= pre_d;
    else if (cs1 && w1) mem1[a1] <= wd1;
    p1[0] <= mem1[a1];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rd1 = p1[2];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic mem_check(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] e);
    check($sformatf("%s mem[%h] L1", nm, a), mem0[a], e);
    check($sformatf("%s mem[%h] L3", nm, a), mem1[a], e);
  endtask

  // Issue one command to both masters and check timing, traffic and status.
  task automatic run_cmd(input int idx, input vec_t v, input bit interfere);
    int c0, c1, ac0, ac1, dc0, dc1, bg0, bg1, bev, rbad;
    bit s0, s1;
    logic e0v, e1v;
    logic [DW-1:0] q0v, q1v;
    c0 = 0; c1 = 0; ac0 = 0; ac1 = 0; dc0 = 0; dc1 = 0;
    bg0 = 0; bg1 = 0; bev = 0; rbad = 0;
    s0 = 1'b0; s1 = 1'b0; e0v = 1'b0; e1v = 1'b0; q0v = '0; q1v = '0;
    @(negedge clk);
    check($sformatf("v%0d ready before accept", idx), 32'({r0, r1}), 32'b11);
    cmd_valid   = 1'b1;
    cmd_op      = v.op;
    cmd_src     = v.src;
    cmd_dst     = v.dst;
    cmd_len     = v.len;
    cmd_pattern = v.pat;
    @(posedge clk);
    for (int n = 1; n <= BOUND && !(s0 && s1); n++) begin
      @(negedge clk);
      dc0 += int'(dn0);
      dc1 += int'(dn1);
      if (!s0) begin
        ac0 += int'(cs0);
        if (!b0) bg0++;
        if (cs0 && be0 != 4'hF) bev++;
        if (interfere && r0) rbad++;
        if (dn0) begin s0 = 1'b1; c0 = n - 1; e0v = e0; q0v = res0; end
      end
      if (!s1) begin
        ac1 += int'(cs1);
        if (!b1) bg1++;
        if (cs1 && be1 != 4'hF) bev++;
        if (interfere && r1) rbad++;
        if (dn1) begin s1 = 1'b1; c1 = n - 1; e1v = e1; q1v = res1; end
      end
      if (interfere && n <= 6) begin
        cmd_valid   = 1'b1;
        cmd_op      = 2'd0;
        cmd_src     = 10'h300;
        cmd_dst     = 10'h204;
        cmd_len     = 11'd4;
        cmd_pattern = 32'hDEAD_BEEF;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    check($sformatf("v%0d done seen", idx), 32'({s0, s1}), 32'b11);
    @(negedge clk);
    dc0 += int'(dn0);
    dc1 += int'(dn1);
    check($sformatf("v%0d idle after done", idx), 32'({b0, r0, b1, r1}), 32'b0101);
    check($sformatf("v%0d cycles L1", idx), 32'(c0), 32'(v.cyc1));
    check($sformatf("v%0d cycles L3", idx), 32'(c1), 32'(v.cyc3));
    check($sformatf("v%0d accesses L1", idx), 32'(ac0), 32'(v.acc));
    check($sformatf("v%0d accesses L3", idx), 32'(ac1), 32'(v.acc));
    check($sformatf("v%0d done pulses", idx), 32'({dc0[7:0], dc1[7:0]}), 32'h0101);
    check($sformatf("v%0d err", idx), 32'({e0v, e1v}), 32'({v.err, v.err}));
    check($sformatf("v%0d busy gaps/byteenable", idx), 32'(bg0 + bg1 + bev), 32'd0);
    if (interfere) check($sformatf("v%0d ready while busy", idx), 32'(rbad), 32'd0);
    if (v.chk) begin
      check($sformatf("v%0d result L1", idx), q0v, v.res);
      check($sformatf("v%0d result L3", idx), q1v, v.res);
    end
  endtask

  initial begin
    //           op     src      dst      len     pat          cyc1  cyc3  acc   err   chk   res
    vecs[0] = '{2'd2, 10'h000, 10'h000, 11'd4,   32'h0,        16'd8,    16'd16,   16'd4,    1'b0, 1'b1, 32'h8};
    vecs[1] = '{2'd0, 10'h000, 10'h3FC, 11'd8,   32'hA5A5A5A5, 16'd8,    16'd8,    16'd8,    1'b0, 1'b0, 32'h0};
    vecs[2] = '{2'd1, 10'h010, 10'h100, 11'd4,   32'h0,        16'd12,   16'd20,   16'd8,    1'b0, 1'b0, 32'h0};
    vecs[3] = '{2'd0, 10'h000, 10'h004, 11'd0,   32'h1234,     16'd0,    16'd0,    16'd0,    1'b0, 1'b0, 32'h0};
    vecs[4] = '{2'd2, 10'h010, 10'h000, 11'd0,   32'h0,        16'd0,    16'd0,    16'd0,    1'b0, 1'b1, 32'h0};
    vecs[5] = '{2'd3, 10'h010, 10'h004, 11'd5,   32'hFFFF,     16'd0,    16'd0,    16'd0,    1'b1, 1'b0, 32'h0};
    vecs[6] = '{2'd1, 10'h010, 10'h104, 11'd0,   32'h0,        16'd0,    16'd0,    16'd0,    1'b0, 1'b0, 32'h0};
    vecs[7] = '{2'd0, 10'h000, 10'h123, 11'h7FF, 32'h1,        16'd1024, 16'd1024, 16'd1024, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{2'd2, 10'h200, 10'h000, 11'h400, 32'h0,        16'd2048, 16'd4096, 16'd1024, 1'b0, 1'b1, 32'h400};
    vecs[9] = '{2'd2, 10'h3FF, 10'h000, 11'h401, 32'h0,        16'd2048, 16'd4096, 16'd1024, 1'b0, 1'b1, 32'h400};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_pattern = '0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    repeat (3) @(negedge clk);
    check("in reset ready/busy/cs", 32'({r0, r1, b0, b1, cs0, cs1}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready after release", 32'({r0, r1}), 32'b11);

    preload(10'h000, 32'hFFFF_FFFF);
    preload(10'h001, 32'd2);
    preload(10'h002, 32'd3);
    preload(10'h003, 32'd4);
    preload(10'h3FB, S1);
    preload(10'h004, S2);
    preload(10'h104, S3);
    for (int k = 0; k < 4; k++) preload(10'h010 + 10'(k), 32'(k + 1));

    for (int i = 0; i < 10; i++) begin
      run_cmd(i, vecs[i], 1'b0);
      case (i)
        1: begin
          for (int k = 0; k < 8; k++) mem_check("fill", 10'h3FC + 10'(k), 32'hA5A5A5A5);
          mem_check("fill below", 10'h3FB, S1);
          mem_check("fill above", 10'h004, S2);
        end
        2: begin
          for (int k = 0; k < 4; k++) mem_check("copy", 10'h100 + 10'(k), 32'(k + 1));
          mem_check("copy past end", 10'h104, S3);
        end
        3, 5: mem_check("no access", 10'h004, S2);
        6: mem_check("copy len0", 10'h104, S3);
        default: ;
      endcase
    end

    // Mid-command reset: COPY of 8 words, reset applied in the 3rd word.
    for (int k = 0; k < 8; k++) preload(10'h020 + 10'(k), 32'h100 + 32'(k));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_src = 10'h020; cmd_dst = 10'h040;
    cmd_len = 11'd8; cmd_pattern = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("rst word2 read", 32'({cs0, w0, a0}), 32'({1'b1, 1'b0, 10'h022}));
    reset_n = 1'b0;
    @(negedge clk);
    check("rst flags L1", 32'({r0, b0, dn0, e0, cs0, w0, be0}), 32'h00F);
    check("rst flags L3", 32'({r1, b1, dn1, e1, cs1, w1, be1}), 32'h00F);
    check("rst addr", 32'({a0, a1}), 32'd0);
    check("rst wdata", wd0 | wd1, 32'd0);
    check("rst result", res0 | res1, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst ready again", 32'({r0, r1}), 32'b11);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rst copy L1 [%0d]", k), mem0[10'h040 + 10'(k)],
            (k < 2) ? 32'h100 + 32'(k) : 32'h1);
      check($sformatf("rst copy L3 [%0d]", k), mem1[10'h040 + 10'(k)],
            (k < 1) ? 32'h100 + 32'(k) : 32'h1);
    end

    // COPY while a conflicting FILL is offered during busy.
    for (int k = 0; k < 4; k++) preload(10'h010 + 10'(k), 32'h20 + 32'(k));
    vx = '{2'd1, 10'h010, 10'h200, 11'd4, 32'h0, 16'd12, 16'd20, 16'd8, 1'b0, 1'b0, 32'h0};
    run_cmd(10, vx, 1'b1);
    for (int k = 0; k < 4; k++) mem_check("busy copy", 10'h200 + 10'(k), 32'h20 + 32'(k));
    for (int k = 4; k < 8; k++) mem_check("ignored fill", 10'h200 + 10'(k), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
